snes_pad_serial_if: RTL and testbench

- Drives the physical SNES controller port: generates LATCH and CLOCK pulses, and shifts in the 16-bit serial button stream.
- Presents a debounced-by-frame, active-high button word to the downstream AXI4-Lite register slave of the snes_controller_reader IP.
- The slave exposes this word in its status register.
- Sits between the PMOD/IO pins and the register block, in the AXI clock domain.

---
 rtl/snes_pad_pkg.sv | 36 +++
 rtl/snes_sync2.sv | 27 ++
 rtl/snes_pad_serial_if.sv | 167 ++++++++++++++++
 tb/tb_snes_pad_serial_if.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pad_pkg.sv
// Shared types and constants for the SNES controller port interface and the
// register block that sits downstream of it.
package snes_pad_pkg;

  localparam int NUM_BITS_DEFAULT = 16;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LATCH      = 3'd1,
    SAMPLE_LOW = 3'd2,
    CLK_HIGH   = 3'd3,
    DONE       = 3'd4
  } snes_if_state_t;

  // Bit positions inside the button word (1 = pressed). Bits 12..15 are the
  // pad's reserved/ID bits and are passed through untouched.
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // Converts a duration in microseconds to clock cycles.
  function automatic int us_to_cycles(input int us, input int cycles_per_us);
    return us * cycles_per_us;
  endfunction

endpackage

// File: rtl/snes_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs. The reset value is a
// parameter so an idle-high line reads as "released" straight out of reset.
module snes_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make meta->q a real two-stage pipeline;
    // blocking ones here would collapse it into a single flop.
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_pad_serial_if.sv
// SNES controller port driver: pulses LATCH, clocks out NUM_BITS serial bits,
// and publishes a whole-frame, active-high button word to the register block.
module snes_pad_serial_if
  import snes_pad_pkg::*;
#(
  parameter int CYCLES_PER_US = 100,
  parameter int LATCH_US      = 12,
  parameter int HALF_US       = 6,
  parameter int POLL_US       = 16667,
  parameter int NUM_BITS      = NUM_BITS_DEFAULT
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                enable,
  input  logic                poll_now,
  input  logic                snes_data,
  output logic                snes_latch,
  output logic                snes_clk,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  output logic                busy,
  output logic [31:0]         frame_count
);

  localparam logic [2:0] S_IDLE       = 3'(IDLE);
  localparam logic [2:0] S_LATCH      = 3'(LATCH);
  localparam logic [2:0] S_SAMPLE_LOW = 3'(SAMPLE_LOW);
  localparam logic [2:0] S_CLK_HIGH   = 3'(CLK_HIGH);
  localparam logic [2:0] S_DONE       = 3'(DONE);

  localparam int LATCH_CYC = us_to_cycles(LATCH_US, CYCLES_PER_US);
  localparam int HALF_CYC  = us_to_cycles(HALF_US, CYCLES_PER_US);
  localparam int POLL_CYC  = us_to_cycles(POLL_US, CYCLES_PER_US);

  localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int POLL_W = $clog2(POLL_CYC + 1);
  localparam int BIT_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [PH_W-1:0]   LATCH_LOAD = PH_W'(LATCH_CYC - 1);
  localparam logic [PH_W-1:0]   HALF_LOAD  = PH_W'(HALF_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LOAD  = POLL_W'(POLL_CYC - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(NUM_BITS - 1);

  logic [2:0]          state, state_next;
  logic [PH_W-1:0]     phase_tmr;
  logic [POLL_W-1:0]   poll_tmr;
  logic [BIT_W-1:0]    bit_idx;
  logic [NUM_BITS-1:0] shift_reg;
  logic                data_sync;
  logic                phase_done;
  logic                poll_expired;
  logic                frame_start;

  snes_sync2 #(.RESET_VAL(1'b1)) u_data_sync (
    .clk (ACLK),
    .rst (ARESET),
    .d   (snes_data),
    .q   (data_sync)
  );

  assign phase_done   = (phase_tmr == '0);
  assign poll_expired = (poll_tmr == '0);

  // Next-state decode; a frame may only start from IDLE, so a poll_now that
  // arrives while busy simply has no effect.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next  = state;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        if ((enable && poll_expired) || poll_now) begin
          frame_start = 1'b1;
          state_next  = S_LATCH;
        end
      end
      S_LATCH:      if (phase_done) state_next = S_SAMPLE_LOW;
      S_SAMPLE_LOW: if (phase_done) state_next = S_CLK_HIGH;
      S_CLK_HIGH: begin
        if (phase_done) state_next = (bit_idx == LAST_BIT) ? S_DONE : S_SAMPLE_LOW;
      end
      S_DONE:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // State register plus registered pin/busy levels decoded from the next
  // state, so the pad sees clean flop outputs in step with the FSM.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      snes_latch <= 1'b0;
      snes_clk   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      snes_latch <= (state_next == S_LATCH);
      snes_clk   <= (state_next != S_SAMPLE_LOW);
      busy       <= (state_next != S_IDLE);
    end
  end

  // Phase timer: loaded on entry to each timed phase, counts down to zero.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      phase_tmr <= '0;
    end else if (state_next != state) begin
      case (state_next)
        S_LATCH:                 phase_tmr <= LATCH_LOAD;
        S_SAMPLE_LOW, S_CLK_HIGH: phase_tmr <= HALF_LOAD;
        default:                 phase_tmr <= '0;
      endcase
    end else if (!phase_done) begin
      phase_tmr <= phase_tmr - 1'b1;
    end
  end

  // Poll timer: free-runs while enabled, restarts at every frame start so the
  // period is start-to-start, and parks at its reload value when disabled.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      poll_tmr <= '0;
    end else if (!enable || frame_start) begin
      poll_tmr <= POLL_LOAD;
    end else if (!poll_expired) begin
      poll_tmr <= poll_tmr - 1'b1;
    end
  end

  // Bit index and serial capture: each bit is taken in the final cycle of its
  // CLOCK-low phase and inverted, since the pad drives 0 for pressed.
  always_ff @(posedge ACLK) begin
    // NOTE: the capture register is reset along with everything else, so a
    // mid-frame reset can never leave stale button bits for the next frame.
    if (ARESET) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (frame_start) begin
        bit_idx <= '0;
      end else if (state == S_CLK_HIGH && phase_done && bit_idx != LAST_BIT) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == S_SAMPLE_LOW && phase_done) begin
        shift_reg[bit_idx] <= ~data_sync;
      end
    end
  end

  // Publish a whole frame at once so partial frames are never visible.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      buttons       <= '0;
      buttons_valid <= 1'b0;
      frame_count   <= '0;
    end else begin
      buttons_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        buttons     <= shift_reg;
        frame_count <= frame_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_serial_if.sv
// Bench for snes_pad_serial_if in fast-simulation timing (1 cycle per us).
// A behavioural 4021-style pad drives the serial line; a pin monitor records
// phase widths and frame events that are compared against the timing rules.
module tb_snes_pad_serial_if;
  import snes_pad_pkg::*;

  localparam int CPU      = 1;
  localparam int LATCH_US = 12;
  localparam int HALF_US  = 6;
  localparam int POLL_US  = 300;
  localparam int NB       = 16;
  localparam int PERIOD   = 10;
  // Cycles from the cycle poll_now is seen to the first cycle buttons_valid shows.
  localparam int FRAME_CYC = LATCH_US + NB * 2 * HALF_US + 2;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          enable = 1'b0;
  logic          poll_now = 1'b0;
  logic          snes_data = 1'b1;
  logic          snes_latch, snes_clk, buttons_valid, busy;
  logic [NB-1:0] buttons;
  logic [31:0]   frame_count;

  snes_pad_serial_if #(
    .CYCLES_PER_US (CPU),
    .LATCH_US      (LATCH_US),
    .HALF_US       (HALF_US),
    .POLL_US       (POLL_US),
    .NUM_BITS      (NB)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enable        (enable),
    .poll_now      (poll_now),
    .snes_data     (snes_data),
    .snes_latch    (snes_latch),
    .snes_clk      (snes_clk),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #(PERIOD / 2) ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pad model: parallel load while LATCH is high, then present the next bit
  // after every rising CLOCK edge; released (1) once all bits are out.
  logic [NB-1:0] pad_pressed = '0;
  bit            pad_present = 1'b1;
  int            pad_idx = NB;
  logic          pad_prev_clk = 1'b1;

  always @(negedge ACLK) begin
    if (snes_latch) pad_idx = 0;
    else if (snes_clk && !pad_prev_clk) pad_idx = pad_idx + 1;
    pad_prev_clk = snes_clk;
    snes_data = (pad_present && pad_idx < NB) ? ~pad_pressed[pad_idx] : 1'b1;
  end

  // Pin monitor: run lengths of each phase and timestamps of frame events.
  longint        latch_rise_t[$], clk_rise_t[$], valid_t[$];
  int            latch_runs[$], low_runs[$], high_runs[$];
  logic [NB-1:0] valid_btn[$];
  int            latch_run = 0, low_run = 0, high_run = 0;
  bit            high_open = 1'b0;
  logic          mon_prev_latch = 1'b0, mon_prev_clk = 1'b1;

  always @(negedge ACLK) begin
    if (snes_latch && !mon_prev_latch) begin
      latch_rise_t.push_back($time);
      high_open = 1'b0;
    end
    if (snes_latch) latch_run++;
    else if (mon_prev_latch) begin
      latch_runs.push_back(latch_run);
      latch_run = 0;
    end
    if (!snes_clk) begin
      low_run++;
      if (mon_prev_clk && high_open) begin
        high_runs.push_back(high_run);
        high_open = 1'b0;
      end
    end else if (!mon_prev_clk) begin
      low_runs.push_back(low_run);
      low_run = 0;
      clk_rise_t.push_back($time);
      high_open = 1'b1;
      high_run  = 1;
    end else if (high_open) begin
      high_run++;
    end
    if (buttons_valid) begin
      valid_t.push_back($time);
      valid_btn.push_back(buttons);
    end
    mon_prev_latch = snes_latch;
    mon_prev_clk   = snes_clk;
  end

  task automatic clear_mon();
    latch_rise_t.delete(); clk_rise_t.delete(); valid_t.delete();
    latch_runs.delete(); low_runs.delete(); high_runs.delete(); valid_btn.delete();
    latch_run = 0; low_run = 0; high_run = 0; high_open = 1'b0;
  endtask

  task automatic pulse_poll(output longint t);
    @(negedge ACLK);
    poll_now = 1'b1;
    t = $time;
    @(negedge ACLK);
    poll_now = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget, output longint t);
    int k = 0;
    while (buttons_valid !== 1'b1 && k < budget) begin
      @(negedge ACLK);
      k++;
    end
    check({name, "_valid_seen"}, 64'(buttons_valid === 1'b1), 64'd1);
    t = $time;
  endtask

  task automatic wait_rises(input string name, input int n, input int budget);
    int   seen = 0;
    int   k = 0;
    logic pc;
    pc = snes_clk;
    while (seen < n && k < budget) begin
      @(negedge ACLK);
      k++;
      if (snes_clk && !pc) seen++;
      pc = snes_clk;
    end
    check({name, "_rises_seen"}, 64'(seen), 64'(n));
  endtask

  // Reference bookkeeping: frames the DUT should have completed so far.
  int unsigned exp_frames = 0;

  task automatic run_frame(input string name, input logic [NB-1:0] pressed, input logic [NB-1:0] exp_btn);
    longint tp, tv;
    pad_pressed = pressed;
    pulse_poll(tp);
    wait_valid(name, FRAME_CYC + 20, tv);
    exp_frames++;
    check({name, "_buttons"}, 64'(buttons), 64'(exp_btn));
    check({name, "_frame_count"}, 64'(frame_count), 64'(exp_frames));
    repeat (3) @(negedge ACLK);
  endtask

  typedef struct {
    string         name;
    logic [NB-1:0] pad_pressed;
    logic [NB-1:0] exp_buttons;
  } vec_t;

  initial begin
    vec_t   vecs[6];
    longint tp, tv;
    int     bad_runs;

    vecs[0] = '{"none",     16'h0000, 16'h0000};
    vecs[1] = '{"all",      16'hFFFF, 16'hFFFF};
    vecs[2] = '{"b_only",   16'h0001, 16'h0001 << BTN_B};
    vecs[3] = '{"id_bit15", 16'h8000, 16'h8000};
    vecs[4] = '{"r_and_a",  16'h0900, (16'h1 << BTN_R) | (16'h1 << BTN_A)};
    vecs[5] = '{"alt",      16'h5AA5, 16'h5AA5};

    // Reset and quiet idle.
    repeat (4) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_latch", 64'(snes_latch), 64'd0);
    check("rst_clk", 64'(snes_clk), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_buttons", 64'(buttons), 64'd0);
    check("rst_valid", 64'(buttons_valid), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    clear_mon();
    repeat (1000) @(negedge ACLK);
    check("idle_no_latch", 64'(latch_rise_t.size()), 64'd0);
    check("idle_no_valid", 64'(valid_t.size()), 64'd0);
    check("idle_clk_high", 64'(snes_clk), 64'd1);

    // Single poll_now frame with detailed pin timing.
    clear_mon();
    pad_pressed = 16'h0A5C;
    pulse_poll(tp);
    wait_valid("frame1", FRAME_CYC + 20, tv);
    exp_frames++;
    check("frame1_buttons", 64'(buttons), 64'h0A5C);
    check("frame1_frame_count", 64'(frame_count), 64'(exp_frames));
    check("frame1_length", 64'((tv - tp) / PERIOD), 64'(FRAME_CYC));
    repeat (20) @(negedge ACLK);
    check("frame1_latch_pulses", 64'(latch_runs.size()), 64'd1);
    if (latch_runs.size() == 1) check("frame1_latch_width", 64'(latch_runs[0]), 64'(LATCH_US));
    check("frame1_low_phases", 64'(low_runs.size()), 64'(NB));
    check("frame1_high_phases", 64'(high_runs.size()), 64'(NB - 1));
    bad_runs = 0;
    foreach (low_runs[i])  if (low_runs[i]  != HALF_US) bad_runs++;
    foreach (high_runs[i]) if (high_runs[i] != HALF_US) bad_runs++;
    check("frame1_half_widths", 64'(bad_runs), 64'd0);
    if (clk_rise_t.size() == NB)
      check("frame1_valid_after_last_high", 64'((tv - clk_rise_t[NB-1]) / PERIOD), 64'(HALF_US + 1));
    check("frame1_valid_pulses", 64'(valid_t.size()), 64'd1);
    check("frame1_busy_after", 64'(busy), 64'd0);

    // Table of fixed button patterns.
    foreach (vecs[i]) run_frame(vecs[i].name, vecs[i].pad_pressed, vecs[i].exp_buttons);

    // Random button patterns.
    for (int i = 0; i < 8; i++) begin
      logic [NB-1:0] r;
      r = NB'($urandom_range(0, (1 << NB) - 1));
      run_frame($sformatf("rand%0d", i), r, r);
    end

    // poll_now during CLK_HIGH of bit 7 is ignored.
    clear_mon();
    pad_pressed = 16'h00F0;
    pulse_poll(tp);
    wait_rises("busy_poll", 8, FRAME_CYC);
    begin
      longint t_ignored;
      pulse_poll(t_ignored);
    end
    wait_valid("busy_poll", FRAME_CYC + 20, tv);
    exp_frames++;
    check("busy_poll_length", 64'((tv - tp) / PERIOD), 64'(FRAME_CYC));
    check("busy_poll_buttons", 64'(buttons), 64'h00F0);
    repeat (300) @(negedge ACLK);
    check("busy_poll_valid_pulses", 64'(valid_t.size()), 64'd1);
    check("busy_poll_latch_pulses", 64'(latch_rise_t.size()), 64'd1);
    check("busy_poll_frame_count", 64'(frame_count), 64'(exp_frames));

    // Auto-poll with a disconnected pad; disabling mid-frame lets it finish.
    clear_mon();
    pad_present = 1'b0;
    @(negedge ACLK);
    enable = 1'b1;
    tp = $time;
    repeat (1250) @(negedge ACLK);
    enable = 1'b0;
    repeat (300) @(negedge ACLK);
    exp_frames += 4;
    check("auto_frames", 64'(valid_t.size()), 64'd4);
    check("auto_latch_pulses", 64'(latch_rise_t.size()), 64'd4);
    if (latch_rise_t.size() == 4) begin
      check("auto_first_start", 64'((latch_rise_t[0] - tp) / PERIOD), 64'(POLL_US));
      for (int i = 1; i < 4; i++)
        check($sformatf("auto_spacing%0d", i),
              64'((latch_rise_t[i] - latch_rise_t[i-1]) / PERIOD), 64'(POLL_US));
    end
    bad_runs = 0;
    foreach (valid_btn[i]) if (valid_btn[i] !== '0) bad_runs++;
    check("auto_released_words", 64'(bad_runs), 64'd0);
    check("auto_buttons", 64'(buttons), 64'd0);
    check("auto_frame_count", 64'(frame_count), 64'(exp_frames));
    check("auto_busy_after", 64'(busy), 64'd0);
    pad_present = 1'b1;

    // Reset in the middle of bit 9 after a frame that left buttons at 0xFFFF.
    run_frame("pre_reset", 16'hFFFF, 16'hFFFF);
    clear_mon();
    pulse_poll(tp);
    wait_rises("mid_reset", 10, FRAME_CYC);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("mid_reset_clk", 64'(snes_clk), 64'd1);
    check("mid_reset_latch", 64'(snes_latch), 64'd0);
    check("mid_reset_buttons", 64'(buttons), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_valid", 64'(buttons_valid), 64'd0);
    check("mid_reset_frame_count", 64'(frame_count), 64'd0);
    ARESET = 1'b0;
    repeat (300) @(negedge ACLK);
    check("post_reset_no_valid", 64'(valid_t.size()), 64'd0);
    check("post_reset_buttons", 64'(buttons), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
